// File: rtl/apb_uart_rx.sv
// apb_uart_rx: UART receiver (8N1) with an APB register port, receive FIFO and sticky error flags.
// Define APB_UART_RX_PARITY_EN to receive 8E1 frames and report parity errors through PERR.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module apb_uart_rx #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   S_PADDR,
  input  logic                   S_PWRITE,
  input  logic                   S_PSELx,
  input  logic                   S_PENABLE,
  input  logic [`DATA_WIDTH-1:0] S_PWDATA,
  output logic [`DATA_WIDTH-1:0] S_PRDATA,
  output logic                   S_PREADY,
  input  logic                   rx_wire,
  output logic                   out,
  output logic [`DATA_WIDTH-1:0] int_data
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [PTR_W:0]   DEPTH    = (PTR_W + 1)'(FIFO_DEPTH);

`ifdef APB_UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
  logic               ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
`ifdef APB_UART_RX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic rx_s, push_req, frame_err, par_err;
  logic acc, rd_data, wr_status, empty, full, push, pop, ovr_set;
  logic [`DATA_WIDTH-1:0] status;
  logic unused_pwdata;

  assign rx_s          = sync2_q;
  assign unused_pwdata = ^{S_PWDATA[`DATA_WIDTH-1:5], S_PWDATA[1:0]};

  always_comb begin
    sync1_d   = rx_wire;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_err = 1'b0;
    par_err   = 1'b0;
`ifdef APB_UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (prev_q && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      // Mid-start check filters short glitches and aligns all later samples to mid-bit.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;
`ifdef APB_UART_RX_PARITY_EN
          if (idx_q == 3'd7) state_d = PARITY;
`else
          if (idx_q == 3'd7) state_d = STOP;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef APB_UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          par_d   = rx_s;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) frame_err = 1'b1;
`ifdef APB_UART_RX_PARITY_EN
          else if (^{shift_q, par_q}) par_err = 1'b1;
`endif
          else push_req = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc       = S_PSELx & S_PENABLE;
  assign rd_data   = acc & ~S_PWRITE & ~S_PADDR;
  assign wr_status = acc & S_PWRITE & S_PADDR;
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH);
  assign pop       = rd_data & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push      = push_req & (~full | pop);
  assign ovr_set   = push_req & full & ~pop;

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    if (pop && !push) count_d = count_q - 1'b1;
    ovr_d    = (ovr_q & ~(wr_status & S_PWDATA[2])) | ovr_set;
    ferr_d   = (ferr_q & ~(wr_status & S_PWDATA[3])) | frame_err;
    perr_d   = (perr_q & ~(wr_status & S_PWDATA[4])) | par_err;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      prev_q   <= 1'b1;
      ovr_q    <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      ovr_q    <= ovr_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef APB_UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
    if (push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    status        = '0;
    status[0]     = ~empty;
    status[1]     = full;
    status[2]     = ovr_q;
    status[3]     = ferr_q;
    status[4]     = perr_q;
    status[11:8]  = 4'(count_q);
    int_data      = empty ? '0 : `DATA_WIDTH'(mem_q[rd_ptr_q]);
    S_PRDATA      = '0;
    if (acc && !S_PWRITE) S_PRDATA = S_PADDR ? status : int_data;
  end

  assign S_PREADY = acc;
  assign out      = ~empty;

endmodule

// File: tb/tb_apb_uart_rx.sv
// tb_apb_uart_rx: randomized + directed bench; reads are scored against a queue-based model by a monitor.
`timescale 1ns/1ps
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_apb_uart_rx;
  localparam int CLK_HZ = 2400;
  localparam int BAUD   = 100;
  localparam int DEPTH  = 8;
  localparam int CPB    = CLK_HZ / BAUD;
`ifdef APB_UART_RX_PARITY_EN
  localparam int STOP_IDX = 10;
`else
  localparam int STOP_IDX = 9;
`endif
  // Edge (counted from the frame's first clock edge) on which the stop bit is judged:
  // two synchronizer flops plus edge detect, half a bit, then whole bits.
  localparam int STOP_EDGE = STOP_IDX * CPB + 3 + CPB / 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        S_PADDR = 1'b0, S_PWRITE = 1'b0, S_PSELx = 1'b0, S_PENABLE = 1'b0;
  logic [15:0] S_PWDATA = '0;
  logic [15:0] S_PRDATA, int_data;
  logic        S_PREADY, out;
  logic        rx_wire = 1'b1;

  always #5 clk = ~clk;

  apb_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .rx_wire(rx_wire), .out(out), .int_data(int_data)
  );

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        irq;
    logic [15:0] idata;
  } exp_t;

  exp_t     exp_q[$];
  int       n_vec = 0;
  int       n_err = 0;
  bit [7:0] m_fifo[$];
  bit       m_ovr, m_ferr, m_perr;

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[0] = (m_fifo.size() != 0);
    s[1] = (m_fifo.size() == DEPTH);
    s[2] = m_ovr;
    s[3] = m_ferr;
    s[4] = m_perr;
    s[11:8] = 4'(m_fifo.size());
    return s;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (S_PSELx && S_PENABLE && !S_PWRITE) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_read: got 0x%04h, expected no read", S_PRDATA);
      end else begin
        e = exp_q.pop_front();
        check({e.name, "_rdata"}, S_PRDATA, e.rdata);
        check({e.name, "_out"}, 16'(out), 16'(e.irq));
        check({e.name, "_int_data"}, int_data, e.idata);
        check({e.name, "_pready"}, 16'(S_PREADY), 16'd1);
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic apb_read(input logic addr, input string name);
    exp_t e;
    e.name  = name;
    e.irq   = (m_fifo.size() != 0);
    e.idata = e.irq ? {8'h00, m_fifo[0]} : 16'h0000;
    e.rdata = addr ? m_status() : e.idata;
    if (!addr && m_fifo.size() != 0) void'(m_fifo.pop_front());
    exp_q.push_back(e);
    S_PADDR = addr; S_PWRITE = 1'b0; S_PSELx = 1'b1; S_PENABLE = 1'b0;
    @(posedge clk); #1;
    S_PENABLE = 1'b1;
    @(posedge clk); #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic addr, input logic [15:0] data);
    if (addr) begin
      if (data[2]) m_ovr = 1'b0;
      if (data[3]) m_ferr = 1'b0;
      if (data[4]) m_perr = 1'b0;
    end
    S_PADDR = addr; S_PWRITE = 1'b1; S_PWDATA = data; S_PSELx = 1'b1; S_PENABLE = 1'b0;
    @(posedge clk); #1;
    S_PENABLE = 1'b1;
    @(posedge clk); #1;
    S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_bit);
    logic [STOP_IDX:0] bits;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef APB_UART_RX_PARITY_EN
    bits[9]   = ^d;
`endif
    bits[STOP_IDX] = stop_bit;
    for (int b = 0; b <= STOP_IDX; b++) begin
      rx_wire = bits[b];
      repeat (CPB) @(posedge clk);
      #1;
    end
    if (!stop_bit) m_ferr = 1'b1;
    else if (m_fifo.size() == DEPTH) m_ovr = 1'b1;
    else m_fifo.push_back(d);
    rx_wire = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    rx_wire = 1'b1;
    m_fifo.delete();
    m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] rd;
    do_reset();
    check("rst_prdata", S_PRDATA, 16'h0000);
    check("rst_out", 16'(out), 16'h0000);
    check("rst_int_data", int_data, 16'h0000);
    check("rst_pready", 16'(S_PREADY), 16'h0000);
    apb_read(1'b1, "rst_status");

    // Single byte; irq must rise on the edge that judges the stop bit.
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (STOP_EDGE) @(posedge clk);
        #1;
        check("a5_out_before_stop", 16'(out), 16'h0000);
        @(posedge clk); #1;
        check("a5_out_after_stop", 16'(out), 16'h0001);
      end
    join
    apb_read(1'b1, "a5_status");
    apb_read(1'b0, "a5_data");
    apb_read(1'b1, "a5_status_after");

    // Overflow: nine bytes into an eight-deep FIFO.
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1);
    apb_read(1'b1, "ovf_status");
    apb_write(1'b1, 16'h0004);
    apb_read(1'b1, "ovf_status_clr");
    for (int i = 0; i < 8; i++) apb_read(1'b0, "ovf_data");
    apb_read(1'b1, "ovf_status_empty");

    // Framing error.
    send_frame(8'h3C, 1'b0);
    apb_read(1'b1, "ferr_status");
    check("ferr_out", 16'(out), 16'h0000);
    apb_write(1'b1, 16'h0008);

    // Short low pulse is rejected at the mid-start check.
    rx_wire = 1'b0;
    repeat (CPB / 4) @(posedge clk);
    #1;
    rx_wire = 1'b1;
    repeat (2 * CPB) @(posedge clk);
    #1;
    apb_read(1'b1, "glitch_status");

    // Full FIFO with a pop on the same edge as the stop-bit push.
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1);
    fork
      send_frame(8'h18, 1'b1);
      begin
        repeat (STOP_EDGE - 1) @(posedge clk);
        #1;
        apb_read(1'b0, "same_cycle_pop");
      end
    join
    apb_read(1'b1, "same_cycle_status");
    for (int i = 0; i < 8; i++) apb_read(1'b0, "same_cycle_data");

    // Reset in the middle of bit 4 of a frame, then a clean frame.
    rd = 8'hC3;
    rx_wire = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int b = 0; b < 5; b++) begin
      #1;
      rx_wire = rd[b];
      repeat ((b == 4) ? CPB / 2 : CPB) @(posedge clk);
    end
    #1;
    do_reset();
    repeat (CPB) @(posedge clk);
    #1;
    send_frame(8'h5A, 1'b1);
    apb_read(1'b1, "midrst_status");
    apb_read(1'b0, "midrst_data");

    // Randomized traffic.
    for (int i = 0; i < 16; i++) begin
      send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 5) != 0));
      for (int r = 0; r < int'($urandom_range(0, 2)); r++)
        apb_read(1'($urandom_range(0, 1)), "rand_read");
      if ($urandom_range(0, 3) == 0) apb_write(1'b1, 16'($urandom_range(0, 31)));
      if ($urandom_range(0, 5) == 0) apb_write(1'b0, 16'($urandom_range(0, 65535)));
    end
    apb_read(1'b1, "rand_status");
    while (m_fifo.size() != 0) apb_read(1'b0, "rand_drain");
    apb_read(1'b1, "rand_final_status");

    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
